// File: rtl/edge_pkg.sv
// Shared constants for the contour point store: frame limits, coordinate
// widths, the {x, y} packing used in edge_positions, and reader FSM encodings.
package edge_pkg;

  // Frame limits; coordinate widths are derived from them.
  localparam int FRAME_W     = 640;
  localparam int FRAME_H     = 480;

  localparam int EDGE_X_W    = $clog2(FRAME_W);  // 10
  localparam int EDGE_Y_W    = $clog2(FRAME_H);  // 9
  localparam int EDGE_ADDR_W = 14;
  localparam int EDGE_PT_W   = EDGE_X_W + EDGE_Y_W;

  // x sits above y in a stored word: {x[18:9], y[8:0]}.
  localparam int X_LSB       = EDGE_Y_W;

  // Reader FSM encodings.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_READ   = 2'd1;
  localparam state_t ST_DRAIN  = 2'd2;
  localparam state_t ST_FINISH = 2'd3;

  // Builds a stored word from a coordinate pair; the tracer writes with this.
  function automatic logic [EDGE_PT_W-1:0] pack_point(input logic [EDGE_X_W-1:0] x,
                                                      input logic [EDGE_Y_W-1:0] y);
    logic [EDGE_PT_W-1:0] w;
    w                       = '0;
    w[X_LSB +: EDGE_X_W]    = x;
    w[EDGE_Y_W-1:0]         = y;
    return w;
  endfunction

endpackage

// File: rtl/edge_position_reader_fifo.sv
// point_fifo: small synchronous FIFO of {last, x, y} entries. The head entry,
// its valid flag and the occupancy count are all held in registers so the
// reader's outputs come straight from flops.
module point_fifo
  import edge_pkg::*;
#(
  parameter  int W     = 20,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_nxt;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     head_q, head_d;
  logic             head_valid_q, head_valid_d;

  assign rd_nxt = rd_ptr_q + 1'b1;

  // Next pointers, count and head entry.
  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it unassigned (no latches).
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    head_d       = head_q;
    head_valid_d = (count_d != '0);
    // The head only moves when it is consumed or when the FIFO was empty.
    if (pop || (count_q == '0)) begin
      if (count_q == CNT_W'(pop)) begin
        // Empty after this pop: a simultaneous push becomes the new head.
        if (push) head_d = push_data;
      end else begin
        head_d = mem_q[rd_nxt];
      end
    end
  end

  // Storage array: written only, never cleared.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset; validity comes from the reset count, and leaving it out keeps it in plain RAM/flops without reset fan-out.
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  assign head_valid = head_valid_q;
  assign head_data  = head_q;
  assign count      = count_q;

endmodule

// File: rtl/edge_position_reader.sv
// edge_position_reader: streams the packed contour points out of the
// edge_positions BRAM in address order as (x, y) over valid/ready, and keeps
// the bounding box of the points that were accepted downstream.
module edge_position_reader
  import edge_pkg::*;
#(
  parameter int ADDR_W     = EDGE_ADDR_W,
  parameter int X_W        = EDGE_X_W,
  parameter int Y_W        = EDGE_Y_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] edge_count,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [X_W+Y_W-1:0] mem_dout,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic [X_W-1:0]    pt_x,
  output logic [Y_W-1:0]    pt_y,
  output logic              pt_last,
  output logic              busy,
  output logic              done,
  output logic [X_W-1:0]    bbox_x_min,
  output logic [X_W-1:0]    bbox_x_max,
  output logic [Y_W-1:0]    bbox_y_min,
  output logic [Y_W-1:0]    bbox_y_max,
  output logic              bbox_valid
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = X_W + Y_W + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_last_q, mem_last_d;
  logic              rd_vld_q;
  logic              rd_last_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              any_acc_q, any_acc_d;
  logic              bbox_valid_q, bbox_valid_d;
  logic [X_W-1:0]    x_min_q, x_min_d, x_max_q, x_max_d;
  logic [Y_W-1:0]    y_min_q, y_min_d, y_max_q, y_max_d;

  logic              fifo_valid;
  logic [ENT_W-1:0]  fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              head_last;
  logic [X_W-1:0]    head_x;
  logic [Y_W-1:0]    head_y;
  logic              pop;
  logic [CNT_W:0]    occ_next;
  logic              room;

  point_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (rd_vld_q),
    .push_data  ({rd_last_q, mem_dout}),
    .pop        (pop),
    .head_valid (fifo_valid),
    .head_data  (fifo_head),
    .count      (fifo_count)
  );

  assign {head_last, head_x, head_y} = fifo_head;
  assign pop = fifo_valid && pt_ready;

  // Slots spoken for after this edge: FIFO contents plus both read stages.
  // A new read may issue only if that still leaves a free slot.
  assign occ_next = {1'b0, fifo_count} + (CNT_W+1)'(rd_vld_q)
                  + (CNT_W+1)'(mem_en_q) - (CNT_W+1)'(pop);
  assign room     = occ_next < (CNT_W+1)'(FIFO_DEPTH);

  // Control FSM, read issue and bounding-box tracking.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_ptr_d     = rd_ptr_q;
    mem_en_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_last_d   = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    any_acc_d    = any_acc_q;
    bbox_valid_d = bbox_valid_q;
    x_min_d      = x_min_q;
    x_max_d      = x_max_q;
    y_min_d      = y_min_q;
    y_max_d      = y_max_q;

    // Only points that actually left through the handshake widen the box.
    if (pop) begin
      any_acc_d = 1'b1;
      if (head_x < x_min_q) x_min_d = head_x;
      if (head_x > x_max_q) x_max_d = head_x;
      if (head_y < y_min_q) y_min_d = head_y;
      if (head_y > y_max_q) y_max_d = head_y;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d       = 1'b1;
          cnt_d        = edge_count;
          any_acc_d    = 1'b0;
          bbox_valid_d = 1'b0;
          x_min_d      = '1;
          x_max_d      = '0;
          y_min_d      = '1;
          y_max_d      = '0;
          if (edge_count == '0) begin
            state_d = ST_FINISH;
          end else begin
            // Address 0 goes out right away so data is back two cycles later.
            state_d    = ST_READ;
            mem_en_d   = 1'b1;
            mem_addr_d = '0;
            mem_last_d = (edge_count == ADDR_W'(1));
            rd_ptr_d   = ADDR_W'(1);
          end
        end
      end
      ST_READ: begin
        if (rd_ptr_q == cnt_q) begin
          state_d = ST_DRAIN;
        end else if (room) begin
          mem_en_d   = 1'b1;
          mem_addr_d = rd_ptr_q;
          mem_last_d = (rd_ptr_q == cnt_q - ADDR_W'(1));
          rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
          if (rd_ptr_q == cnt_q - ADDR_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Finished once nothing remains buffered or in flight after this edge.
        if (occ_next == '0) begin
          state_d      = ST_FINISH;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          bbox_valid_d = any_acc_d;
        end
      end
      ST_FINISH: begin
        // Entered with done already raised from DRAIN, or fresh from an empty
        // run, in which case done is raised here first.
        if (done_q) begin
          state_d = ST_IDLE;
        end else begin
          done_d       = 1'b1;
          busy_d       = 1'b0;
          bbox_valid_d = any_acc_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control, read pipeline and bounding-box registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_last_q   <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      any_acc_q    <= 1'b0;
      bbox_valid_q <= 1'b0;
      x_min_q      <= '0;
      x_max_q      <= '0;
      y_min_q      <= '0;
      y_max_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_en_q     <= mem_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_last_q   <= mem_last_d;
      rd_vld_q     <= mem_en_q;
      rd_last_q    <= mem_last_q;
      busy_q       <= busy_d;
      done_q       <= done_d;
      any_acc_q    <= any_acc_d;
      bbox_valid_q <= bbox_valid_d;
      x_min_q      <= x_min_d;
      x_max_q      <= x_max_d;
      y_min_q      <= y_min_d;
      y_max_q      <= y_max_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_addr   = mem_addr_q;
  assign pt_valid   = fifo_valid;
  assign pt_x       = head_x;
  assign pt_y       = head_y;
  assign pt_last    = head_last;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bbox_x_min = x_min_q;
  assign bbox_x_max = x_max_q;
  assign bbox_y_min = y_min_q;
  assign bbox_y_max = y_max_q;
  assign bbox_valid = bbox_valid_q;

endmodule

// File: doc/edge_position_reader.md
# edge_position_reader

Reads back the packed contour points that the contour-separation tracer stores in the `edge_positions` BRAM and streams them in address order as (x, y) coordinates over a valid/ready handshake. It also reports the contour's bounding box. It sits between the `edge_positions` read port and downstream consumers (overlay renderer, polygon fitter).

## Interface
Parameters:
- `ADDR_W`, 14: `edge_positions` address width.
- `X_W`, 10: x coordinate width.
- `Y_W`, 9: y coordinate width.
- `FIFO_DEPTH`, 4: output buffer depth, power of two, ≥ 2.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: one-cycle pulse; ignored unless idle.
- `edge_count`, in, ADDR_W: number of valid entries, 0…2^ADDR_W−1; sampled with `start`.
- `mem_en`, out, 1: BRAM read enable.
- `mem_addr`, out, ADDR_W: BRAM read address.
- `mem_dout`, in, X_W+Y_W: BRAM data; valid 1 cycle after `mem_en`. Packing is {x[18:9], y[8:0]}.
- `pt_valid`, out, 1: output point valid.
- `pt_ready`, in, 1: downstream accepts the point.
- `pt_x`, out, X_W: point x coordinate.
- `pt_y`, out, Y_W: point y coordinate.
- `pt_last`, out, 1: marks entry `edge_count−1`.
- `busy`, out, 1: high from `start` accepted until `done`.
- `done`, out, 1: one-cycle pulse after the last point is accepted.
- `bbox_x_min`, `bbox_x_max`, out, X_W: bounding-box x extent.
- `bbox_y_min`, `bbox_y_max`, out, Y_W: bounding-box y extent.
- `bbox_valid`, out, 1: high after `done` if at least one point was accepted; cleared by the next `start`.

## Operation
- FSM states are IDLE, READ, DRAIN and FINISH.
- IDLE → READ on `start` when `edge_count` ≠ 0. Latches the count, clears the read pointer, and resets the bbox to min = all-ones, max = 0.
- IDLE → FINISH on `start` when `edge_count` = 0. No memory access is made and no points are emitted.
- READ: issues one read per cycle at addresses 0, 1, 2, … while free FIFO slots exceed in-flight reads.
  - The free-slot count includes a pop happening in the same cycle.
  - Goes to DRAIN after issuing address `edge_count−1`.
- DRAIN: no reads are issued. Goes to FINISH when the FIFO is empty and nothing is in flight.
- FINISH: pulses `done` for one cycle, drops `busy`, and returns to IDLE.
- Returned `mem_dout` is written into the FIFO together with a last flag (address == `edge_count−1`).
- The FIFO head drives `pt_x`, `pt_y`, `pt_last` and `pt_valid`. A pop happens when `pt_valid && pt_ready`.
- On every accepted point, min/max are updated with unsigned compares. The box therefore reflects only accepted points.
- Coordinates are passed through unmodified; there is no range check.
- Output data is held stable while `pt_valid && !pt_ready`.
- `start` while busy is ignored and has no effect on the count or the bbox.
- The FIFO never overflows. `mem_dout` is never sampled without a matching `mem_en` one cycle earlier.

## Timing
- Reset values:
  - Control outputs: `mem_en`, `pt_valid`, `pt_last`, `busy`, `done` and `bbox_valid` are 0.
  - Data outputs: `mem_addr`, `pt_x`, `pt_y` and all bbox outputs are 0.
- Reset mid-operation: returns to IDLE immediately. In-flight data is discarded and no `done` pulse is produced.
- Latency with `start` at edge 0:
  - `busy` and `mem_en` are high in cycle 1, with `mem_addr` = 0.
  - The data is captured at the end of cycle 2.
  - `pt_valid` rises in cycle 3.
- Throughput: with `pt_ready` held high, one point per cycle. N points occupy cycles 3…N+2.
- `done` is asserted in the cycle after the handshake of the `pt_last` point.
- Zero-count run: `busy` is high in cycle 1 and `done` pulses in cycle 2.
- All outputs are registered.

## Structure
- Package `edge_pkg` holds:
  - the widths X_W, Y_W and ADDR_W;
  - the packing offsets (X_LSB = 9);
  - frame limits 640 × 480;
  - the FSM state enum.
- The contour tracer imports the same packing constants from `edge_pkg`.
- One sub-module, `point_fifo`: synchronous FIFO of {last, x, y} with registered head and count output.

## Test plan
- `edge_count` = 3, memory holds {10,5}, {11,5}, {11,6}, `pt_ready` = 1 → points in cycles 3, 4, 5 with `pt_last` only on {11,6}. `done` pulses in cycle 6. Bbox is x 10..11, y 5..6 with `bbox_valid` = 1.
- `edge_count` = 0 → `done` pulses in cycle 2, `mem_en` never asserts, `pt_valid` never asserts, `bbox_valid` = 0.
- `edge_count` = 64 with random `pt_ready` (50%):
  - all 64 points arrive in order and match memory;
  - data stays stable during stalls;
  - in-flight reads never exceed free FIFO slots.
- `pt_ready` = 0 for 20 cycles → at most FIFO_DEPTH reads issued. Release → the stream resumes without loss or duplication.
- `rst_n` low mid-stream at point 10 of 50 → all outputs return to reset values immediately. A new `start` restarts from address 0.
- Second `start` while busy → ignored, and the original count completes unchanged.
